// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: handshaked instruction fetch,
// registered one-cycle control strobes, flag-conditioned jumps and I/O stalls.
module instr_sequencer #(
  parameter  int DATA_W = 8,
  parameter  int PC_W   = 8,
  localparam int OPD_W  = DATA_W - 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              fetch_req,
  output logic [PC_W-1:0]   fetch_addr,
  input  logic              fetch_ack,
  input  logic [DATA_W-1:0] fetch_data,
  input  logic              zero_flag,
  input  logic              carry_flag,
  input  logic              io_ack,
  output logic              in_en,
  output logic              out_en,
  output logic              load_en,
  output logic              alu_en,
  output logic [2:0]        alu_op,
  output logic [OPD_W-1:0]  operand,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_IOWAIT,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_IN   = 4'h0,
    OP_OUT  = 4'h1,
    OP_LOAD = 4'h2,
    OP_ADD  = 4'h3,
    OP_SUB  = 4'h4,
    OP_AND  = 4'h5,
    OP_OR   = 4'h6,
    OP_XOR  = 4'h7,
    OP_JUMP = 4'h8,
    OP_JZ   = 4'h9,
    OP_JNZ  = 4'hA,
    OP_JC   = 4'hB,
    OP_JNC  = 4'hC,
    OP_NOP  = 4'hD,
    OP_HALT = 4'hE,
    OP_ILL  = 4'hF
  } opc_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [DATA_W-1:0]   r_ir;
  opc_e                r_opcode;
  logic [OPD_W-1:0]    r_operand;
  logic [PC_W-1:0]     r_pc;
  logic                r_load;
  logic                r_alu;
  logic [2:0]          r_alu_op;
  logic                r_in;
  logic                r_out;
  logic                r_illegal;

  opc_e                w_dec_op;
  logic                w_dec_alu;
  logic [2:0]          w_dec_alu_op;
  logic                w_is_io;
  logic                w_taken;
  logic                w_done;
  logic [PC_W-1:0]     w_jump_tgt;

  assign w_dec_op   = opc_e'(r_ir[DATA_W-1 -: 4]);
  assign w_is_io    = (r_opcode == OP_IN) || (r_opcode == OP_OUT);
  assign w_jump_tgt = PC_W'(r_operand);

  // Completion point of an instruction: the only place the PC moves.
  assign w_done = ((r_state == S_EXEC) && (!w_is_io || io_ack)) ||
                  ((r_state == S_IOWAIT) && io_ack);

  always_comb begin
    w_dec_alu    = 1'b0;
    w_dec_alu_op = 3'd0;
    case (w_dec_op)
      OP_ADD:  begin w_dec_alu = 1'b1; w_dec_alu_op = 3'd0; end
      OP_SUB:  begin w_dec_alu = 1'b1; w_dec_alu_op = 3'd1; end
      OP_AND:  begin w_dec_alu = 1'b1; w_dec_alu_op = 3'd2; end
      OP_OR:   begin w_dec_alu = 1'b1; w_dec_alu_op = 3'd3; end
      OP_XOR:  begin w_dec_alu = 1'b1; w_dec_alu_op = 3'd4; end
      default: begin w_dec_alu = 1'b0; w_dec_alu_op = 3'd0; end
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    case (r_opcode)
      OP_JUMP: w_taken = 1'b1;
      OP_JZ:   w_taken = zero_flag;
      OP_JNZ:  w_taken = ~zero_flag;
      OP_JC:   w_taken = carry_flag;
      OP_JNC:  w_taken = ~carry_flag;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  if (fetch_ack) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if ((w_dec_op == OP_ILL) || (w_dec_op == OP_HALT)) w_state_nxt = S_HALT;
        else                                                  w_state_nxt = S_EXEC;
      end
      S_EXEC:   w_state_nxt = (w_is_io && !io_ack) ? S_IOWAIT : S_FETCH;
      S_IOWAIT: if (io_ack) w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_opcode  <= OP_NOP;
      r_operand <= '0;
      r_pc      <= '0;
      r_load    <= 1'b0;
      r_alu     <= 1'b0;
      r_alu_op  <= 3'd0;
      r_in      <= 1'b0;
      r_out     <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      if ((r_state == S_FETCH) && fetch_ack) r_ir <= fetch_data;

      // Strobes are loaded here so they appear exactly in the EXEC cycle.
      if (r_state == S_DECODE) begin
        r_opcode  <= w_dec_op;
        r_operand <= r_ir[OPD_W-1:0];
        r_illegal <= (w_dec_op == OP_ILL);
        r_load    <= (w_dec_op == OP_LOAD);
        r_alu     <= w_dec_alu;
        r_alu_op  <= w_dec_alu_op;
        r_in      <= (w_dec_op == OP_IN);
        r_out     <= (w_dec_op == OP_OUT);
      end

      if (r_state == S_EXEC) begin
        r_load   <= 1'b0;
        r_alu    <= 1'b0;
        r_alu_op <= 3'd0;
      end

      if (w_done) begin
        r_in  <= 1'b0;
        r_out <= 1'b0;
        r_pc  <= w_taken ? w_jump_tgt : r_pc + PC_W'(1);
      end
    end
  end

  assign fetch_req  = (r_state == S_FETCH);
  assign fetch_addr = r_pc;
  assign pc         = r_pc;
  assign operand    = r_operand;
  assign load_en    = r_load;
  assign alu_en     = r_alu;
  assign alu_op     = r_alu_op;
  assign in_en      = r_in;
  assign out_en     = r_out;
  assign halted     = (r_state == S_HALT);
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed plus randomized bench for instr_sequencer against an instruction-level
// model: PC follows the jump/increment rules, strobes follow the opcode table.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       fetch_ack;
  logic [7:0] fetch_data;
  logic       zero_flag;
  logic       carry_flag;
  logic       io_ack;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       in_en;
  logic       out_en;
  logic       load_en;
  logic       alu_en;
  logic [2:0] alu_op;
  logic [3:0] operand;
  logic [7:0] pc;
  logic       halted;
  logic       illegal;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_pc;

  instr_sequencer #(.DATA_W(8), .PC_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ack  (fetch_ack),
    .fetch_data (fetch_data),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .io_ack     (io_ack),
    .in_en      (in_en),
    .out_en     (out_en),
    .load_en    (load_en),
    .alu_en     (alu_en),
    .alu_op     (alu_op),
    .operand    (operand),
    .pc         (pc),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] vec();
    return {fetch_req, load_en, alu_en, in_en, out_en};
  endfunction

  function automatic bit jump_taken(input logic [3:0] op, input bit z, input bit c);
    case (op)
      4'h8:    return 1'b1;
      4'h9:    return z;
      4'hA:    return !z;
      4'hB:    return c;
      4'hC:    return !c;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] rand_instr(input bit allow_jump);
    logic [3:0] op;
    int         r;
    if (allow_jump) op = 4'($urandom_range(0, 13));
    else begin
      r  = $urandom_range(0, 8);
      op = (r == 8) ? 4'hD : 4'(r);
    end
    return {op, 4'($urandom)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_strobes"}, 32'(vec()), 32'd0);
    chk({tag, "_pc"}, 32'(pc), 32'd0);
    chk({tag, "_operand"}, 32'(operand), 32'd0);
    chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    chk({tag, "_status"}, {30'd0, halted, illegal}, 32'd0);
  endtask

  task automatic do_start();
    fetch_ack = 1'b0;
    chk("idle_no_req", 32'(fetch_req), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    m_pc  = 8'h00;
  endtask

  // Entered at the negedge of the first FETCH cycle, leaves at the DECODE negedge.
  task automatic fetch_phase(input logic [7:0] ins, input int ack_wait);
    fetch_ack = 1'b0;
    chk("fetch_addr", 32'(fetch_addr), 32'(m_pc));
    for (int i = 0; i < ack_wait; i++) begin
      chk("fetch_stall", 32'(vec()), 32'b10000);
      io_ack = 1'($urandom);
      step();
    end
    chk("fetch_req", 32'(vec()), 32'b10000);
    chk("fetch_addr_held", 32'(fetch_addr), 32'(m_pc));
    fetch_ack  = 1'b1;
    fetch_data = ins;
    step();
    fetch_ack  = 1'b0;
    fetch_data = 8'($urandom);
    chk("decode_no_strobe", 32'(vec()), 32'd0);
  endtask

  task automatic exec_phase(input logic [7:0] ins, input int io_wait, input bit z, input bit c);
    logic [3:0] op;
    logic [3:0] opd;
    bit         is_io;
    logic [4:0] exp_vec;
    logic [2:0] exp_aop;
    op      = ins[7:4];
    opd     = ins[3:0];
    is_io   = (op == 4'h0) || (op == 4'h1);
    exp_vec = {1'b0, op == 4'h2, (op >= 4'h3) && (op <= 4'h7), op == 4'h0, op == 4'h1};
    exp_aop = ((op >= 4'h3) && (op <= 4'h7)) ? 3'(op - 4'h3) : 3'd0;
    // Decoy flags and acks outside the cycles in which they are sampled.
    zero_flag  = 1'($urandom);
    carry_flag = 1'($urandom);
    io_ack     = 1'($urandom);
    fetch_ack  = 1'($urandom);
    step();
    chk("exec_strobes", 32'(vec()), 32'(exp_vec));
    chk("exec_alu_op", 32'(alu_op), 32'(exp_aop));
    chk("exec_operand", 32'(operand), 32'(opd));
    chk("exec_pc", 32'(pc), 32'(m_pc));
    zero_flag  = z;
    carry_flag = c;
    io_ack     = is_io ? (io_wait == 0) : 1'($urandom);
    step();
    if (is_io) begin
      for (int k = 1; k <= io_wait; k++) begin
        chk("iowait_hold", 32'(vec()), 32'(exp_vec));
        chk("iowait_pc", 32'(pc), 32'(m_pc));
        io_ack = (k == io_wait);
        step();
      end
    end
    io_ack    = 1'b0;
    fetch_ack = 1'b0;
    m_pc = jump_taken(op, z, c) ? {4'h0, opd} : m_pc + 8'd1;
    chk("next_pc", 32'(pc), 32'(m_pc));
    chk("next_fetch", 32'(vec()), 32'b10000);
    chk("next_alu_op", 32'(alu_op), 32'd0);
  endtask

  task automatic run_instr(input logic [7:0] ins, input int ack_wait, input int io_wait,
                           input bit z, input bit c);
    fetch_phase(ins, ack_wait);
    exec_phase(ins, io_wait, z, c);
  endtask

  task automatic run_random(input bit allow_jump);
    run_instr(rand_instr(allow_jump), $urandom_range(0, 2), $urandom_range(0, 3),
              1'($urandom), 1'($urandom));
  endtask

  task automatic halt_phase(input logic [7:0] ins, input bit exp_illegal);
    fetch_phase(ins, 0);
    step();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_illegal", 32'(illegal), 32'(exp_illegal));
    chk("halt_strobes", 32'(vec()), 32'd0);
    chk("halt_pc", 32'(pc), 32'(m_pc));
    start     = 1'b1;
    fetch_ack = 1'b1;
    io_ack    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("halt_stays", {29'd0, halted, illegal, fetch_req}, {29'd0, 1'b1, exp_illegal, 1'b0});
      chk("halt_pc_frozen", 32'(pc), 32'(m_pc));
    end
    start     = 1'b0;
    fetch_ack = 1'b0;
    io_ack    = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1 chk_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    fetch_ack  = 1'b0;
    fetch_data = 8'h00;
    zero_flag  = 1'b0;
    carry_flag = 1'b0;
    io_ack     = 1'b0;
    m_pc       = 8'h00;
    #1 chk_reset("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_reset("idle_after_reset");

    // LOAD 5 with zero-wait ack: strobe in cycle 3, next fetch in cycle 4.
    do_start();
    run_instr(8'h25, 0, 0, 1'b0, 1'b0);

    // ALU group back to back.
    run_instr(8'h31, 0, 0, 1'b0, 1'b0);
    run_instr(8'h41, 0, 0, 1'b0, 1'b0);
    run_instr(8'h51, 0, 0, 1'b0, 1'b0);
    run_instr(8'h61, 0, 0, 1'b0, 1'b0);
    run_instr(8'h71, 0, 0, 1'b0, 1'b0);

    // Conditional jumps, not taken then taken.
    run_instr(8'h9A, 0, 0, 1'b0, 1'b0);
    run_instr(8'h9A, 0, 0, 1'b1, 1'b0);
    run_instr(8'hAA, 0, 0, 1'b1, 1'b0);
    run_instr(8'hAA, 0, 0, 1'b0, 1'b0);
    run_instr(8'hBA, 0, 0, 1'b0, 1'b0);
    run_instr(8'hBA, 0, 0, 1'b0, 1'b1);
    run_instr(8'hCA, 0, 0, 1'b0, 1'b1);
    run_instr(8'hCA, 0, 0, 1'b0, 1'b0);
    run_instr(8'h8F, 1, 0, 1'b1, 1'b1);

    // I/O: delayed and immediate acknowledge; a stalled fetch.
    run_instr(8'h10, 0, 4, 1'b0, 1'b0);
    run_instr(8'h03, 0, 0, 1'b0, 1'b0);
    run_instr(8'h27, 2, 0, 1'b0, 1'b0);

    // Walk the PC up to the top of the address space, then wrap on a NOP.
    for (int n = 0; n < 300 && m_pc != 8'hFF; n++) run_random(1'b0);
    chk("walk_reach_ff", 32'(pc), 32'hFF);
    run_instr(8'hD0, 0, 0, 1'b0, 1'b0);
    chk("nop_wrap", 32'(pc), 32'h00);

    for (int n = 0; n < 80; n++) run_random(1'b1);

    // Reset during IOWAIT.
    fetch_phase(8'h10, 0);
    io_ack = 1'b0;
    step();
    step();
    step();
    chk("iowait_before_reset", 32'(vec()), 32'b00001);
    async_reset("rst_iowait");
    do_start();
    run_instr(8'h25, 0, 0, 1'b0, 1'b0);

    // Reset while the fetch is stalled.
    fetch_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_before_reset", 32'(vec()), 32'b10000);
      step();
    end
    async_reset("rst_fetch");
    do_start();
    run_instr(8'h34, 0, 0, 1'b0, 1'b0);
    run_random(1'b0);

    // Illegal opcode, then a clean HALT after reset.
    halt_phase(8'hF3, 1'b1);
    async_reset("rst_after_illegal");
    do_start();
    run_random(1'b0);
    run_random(1'b0);
    halt_phase(8'hE0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
